// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master system bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SLAVE = 2'd1,
    GRANT      = 2'd2,
    RELEASE    = 2'd3
  } state_t;

  typedef logic master_t;
  localparam master_t M1 = 1'b0;
  localparam master_t M2 = 1'b1;

  localparam int unsigned SEL_W              = 2;
  localparam logic [SEL_W-1:0] SEL_NONE      = 2'b11;
  localparam int unsigned SLAVE_ADDR_MSB     = 13;
  localparam int unsigned SLAVE_ADDR_LSB     = 12;
  localparam int unsigned DEFAULT_TIMEOUT    = 255;
  localparam int unsigned DEFAULT_NUM_SLAVES = 3;

  // Arbitration result latched for the duration of one transaction.
  typedef struct packed {
    master_t          id;
    logic [SEL_W-1:0] sel;
  } arb_win_t;

  function automatic logic [SEL_W-1:0] addr_to_sel(input logic [31:0] addr);
    return addr[SLAVE_ADDR_MSB:SLAVE_ADDR_LSB];
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-request / slave-select signal bundle around the bus arbiter.
interface bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = DEFAULT_NUM_SLAVES
) ();

  logic                  m1_req;
  logic                  m2_req;
  logic [SEL_W-1:0]      m1_slave_sel;
  logic [SEL_W-1:0]      m2_slave_sel;
  logic [NUM_SLAVES-1:0] slave_ready;
  logic                  trans_done;
  logic                  m1_grant;
  logic                  m2_grant;
  logic [SEL_W-1:0]      slave_sel;
  logic [NUM_SLAVES-1:0] slave_en;
  logic                  bus_busy;
  logic                  err;

  // Arbiter side.
  modport slave (
    input  m1_req, m2_req, m1_slave_sel, m2_slave_sel, slave_ready, trans_done,
    output m1_grant, m2_grant, slave_sel, slave_en, bus_busy, err
  );

  // Master / system side.
  modport master (
    output m1_req, m2_req, m1_slave_sel, m2_slave_sel, slave_ready, trans_done,
    input  m1_grant, m2_grant, slave_sel, slave_en, bus_busy, err
  );

endinterface

// File: rtl/arb_timeout_counter.sv
// Saturating cycle counter that flags when TIMEOUT cycles have elapsed.
module arb_timeout_counter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: round-robin on ties, waits for slave ready, holds
// the grant until trans_done, request drop or timeout.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = DEFAULT_NUM_SLAVES,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input logic         clk,
  input logic         reset,
  bus_arbiter_if.slave bus
);

  state_t   state, next_state;
  arb_win_t win, win_next;
  master_t  last_winner;
  logic     expired, winner_req, sel_invalid, ready_sel, abort_err;

  logic                  m1_grant_d, m2_grant_d, bus_busy_d, err_d;
  logic [SEL_W-1:0]      slave_sel_d;
  logic [NUM_SLAVES-1:0] slave_en_d;

  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (next_state != state),
    .enable  ((state == WAIT_SLAVE) || (state == GRANT)),
    .expired (expired)
  );

  assign winner_req  = (win.id == M1) ? bus.m1_req : bus.m2_req;
  assign sel_invalid = (win.sel == SEL_NONE) || (32'(win.sel) >= NUM_SLAVES);

  always_comb begin
    ready_sel = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (win.sel == SEL_W'(i)) ready_sel = bus.slave_ready[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    abort_err  = 1'b0;
    win_next   = win;
    case (state)
      IDLE: begin
        if (bus.m1_req || bus.m2_req) begin
          next_state = WAIT_SLAVE;
          if (bus.m1_req && bus.m2_req) win_next.id = (last_winner == M1) ? M2 : M1;
          else                          win_next.id = bus.m1_req ? M1 : M2;
          win_next.sel = (win_next.id == M1) ? bus.m1_slave_sel : bus.m2_slave_sel;
        end
      end
      WAIT_SLAVE: begin
        if (sel_invalid) begin
          next_state = RELEASE;
          abort_err  = 1'b1;
        end else if (!winner_req) begin
          next_state = RELEASE;
        end else if (ready_sel) begin
          next_state = GRANT;
        end else if (expired) begin
          next_state = RELEASE;
          abort_err  = 1'b1;
        end
      end
      GRANT: begin
        // Completion takes precedence over a coincident timeout.
        if (bus.trans_done || !winner_req) begin
          next_state = RELEASE;
        end else if (expired) begin
          next_state = RELEASE;
          abort_err  = 1'b1;
        end
      end
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output registers load from the next state so grant appears on GRANT entry.
  always_comb begin
    m1_grant_d  = 1'b0;
    m2_grant_d  = 1'b0;
    slave_sel_d = SEL_NONE;
    slave_en_d  = '0;
    bus_busy_d  = (next_state != IDLE);
    err_d       = abort_err;
    if (next_state == GRANT) begin
      m1_grant_d  = (win_next.id == M1);
      m2_grant_d  = (win_next.id == M2);
      slave_sel_d = win_next.sel;
      for (int i = 0; i < NUM_SLAVES; i++) begin
        slave_en_d[i] = (win_next.sel == SEL_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win         <= '{id: M1, sel: SEL_NONE};
      last_winner <= M2;
    end else begin
      win <= win_next;
      if (state == RELEASE) last_winner <= win.id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.m1_grant  <= 1'b0;
      bus.m2_grant  <= 1'b0;
      bus.slave_sel <= SEL_NONE;
      bus.slave_en  <= '0;
      bus.bus_busy  <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.m1_grant  <= m1_grant_d;
      bus.m2_grant  <= m2_grant_d;
      bus.slave_sel <= slave_sel_d;
      bus.slave_en  <= slave_en_d;
      bus.bus_busy  <= bus_busy_d;
      bus.err       <= err_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed transactions and random ones
// predicted from the transaction timeline (grant edge, release edge, err).
module tb_bus_arbiter;

  localparam int unsigned NS = 3;
  localparam int          TO = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_SLAVES(NS)) bif ();

  bus_arbiter #(.NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit last_m2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit g1, input bit g2,
                               input logic [1:0] sel, input logic [2:0] en,
                               input bit busy, input bit e);
    check({tag, ".m1_grant"},  32'(bif.m1_grant),  32'(g1));
    check({tag, ".m2_grant"},  32'(bif.m2_grant),  32'(g2));
    check({tag, ".slave_sel"}, 32'(bif.slave_sel), 32'(sel));
    check({tag, ".slave_en"},  32'(bif.slave_en),  32'(en));
    check({tag, ".bus_busy"},  32'(bif.bus_busy),  32'(busy));
    check({tag, ".err"},       32'(bif.err),       32'(e));
  endtask

  // Ready of the target slave is high at edge kk iff kk >= rdy; others random.
  task automatic drive_ready(input logic [1:0] sel, input int kk, input int rdy);
    logic [2:0] v;
    v = 3'($urandom);
    if (sel != 2'b11) v[sel] = (kk >= rdy);
    bif.slave_ready = v;
  endtask

  // Edge 1 is the IDLE edge that samples the requests; cycle k follows edge k.
  task automatic txn(input string tag, input bit r1, input bit r2,
                     input logic [1:0] s1, input logic [1:0] s2,
                     input int rdy, input int dly);
    bit wm2, granted, errx, gnow;
    logic [1:0] sel;
    int g, rel;
    wm2     = (r1 && r2) ? !last_m2 : r2;
    sel     = wm2 ? s2 : s1;
    granted = 1'b0;
    errx    = 1'b1;
    g       = 0;
    if (sel == 2'b11) begin
      rel = 2;
    end else begin
      g = (rdy > 2) ? rdy : 2;
      if (g > TO + 2) begin
        rel = TO + 2;
      end else begin
        granted = 1'b1;
        if (dly > 0 && dly <= TO + 1) begin
          rel  = g + dly;
          errx = 1'b0;
        end else begin
          rel = g + TO + 1;
        end
      end
    end
    bif.m1_req       = r1;
    bif.m2_req       = r2;
    bif.m1_slave_sel = s1;
    bif.m2_slave_sel = s2;
    bif.trans_done   = 1'b0;
    drive_ready(sel, 1, rdy);
    for (int k = 1; k <= rel + 1; k++) begin
      @(posedge clk); #1;
      gnow = granted && (k >= g) && (k < rel);
      check_outputs($sformatf("%s.c%0d", tag, k), gnow && !wm2, gnow && wm2,
                    gnow ? sel : 2'b11, gnow ? 3'(1 << sel) : 3'b000,
                    k <= rel, errx && (k == rel));
      if (k <= rel) begin
        int kk = k + 1;
        if (kk == rel + 1) begin
          if (wm2) bif.m2_req = 1'b0;
          else     bif.m1_req = 1'b0;
        end
        bif.m1_slave_sel = 2'($urandom);
        bif.m2_slave_sel = 2'($urandom);
        drive_ready(sel, kk, rdy);
        bif.trans_done = (granted && kk == g + dly) ||
                         ((!granted || kk <= g) && $urandom_range(0, 7) == 0);
      end
    end
    bif.trans_done = 1'b0;
    last_m2 = wm2;
  endtask

  initial begin
    reset            = 1'b1;
    bif.m1_req       = 1'b0;
    bif.m2_req       = 1'b0;
    bif.m1_slave_sel = 2'b00;
    bif.m2_slave_sel = 2'b00;
    bif.slave_ready  = 3'b000;
    bif.trans_done   = 1'b0;
    last_m2          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, 0, 2'b11, 3'b000, 0, 0);
    reset = 1'b0;

    txn("lone_m1", 1, 0, 2'd0, 2'd0, 0, 1);
    txn("tie1_m1", 1, 1, 2'd1, 2'd2, 0, 3);
    txn("tie1_m2", 0, 1, 2'd1, 2'd2, 0, 2);
    txn("tie2_m1", 1, 1, 2'd1, 2'd2, 0, 4);
    txn("not_ready", 0, 1, 2'd0, 2'd2, 11, 2);
    txn("wait_timeout", 1, 0, 2'd1, 2'd0, 100, 1);
    txn("grant_timeout", 0, 1, 2'd0, 2'd1, 0, -1);
    txn("done_vs_timeout", 1, 0, 2'd2, 2'd0, 0, TO + 1);
    txn("invalid_sel", 1, 0, 2'b11, 2'd0, 0, 1);

    // Reset while granted drops the transaction silently.
    bif.m1_req       = 1'b1;
    bif.m2_req       = 1'b0;
    bif.m1_slave_sel = 2'd0;
    bif.slave_ready  = 3'b111;
    repeat (4) @(posedge clk);
    #1;
    check("mid_grant.m1_grant", 32'(bif.m1_grant), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_outputs("mid_reset", 0, 0, 2'b11, 3'b000, 0, 0);
    reset      = 1'b0;
    bif.m1_req = 1'b0;
    last_m2    = 1'b1;
    @(posedge clk); #1;
    check_outputs("post_reset", 0, 0, 2'b11, 3'b000, 0, 0);
    txn("tie_after_reset", 1, 1, 2'd2, 2'd0, 0, 2);

    for (int i = 0; i < 40; i++) begin
      bit a, b;
      logic [1:0] sa, sb;
      int rdy, dly;
      a   = 1'($urandom_range(0, 1));
      b   = 1'($urandom_range(0, 1));
      if (!a && !b) a = 1'b1;
      sa  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      sb  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rdy = $urandom_range(0, 20);
      dly = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(1, 18);
      txn($sformatf("rnd%0d", i), a, b, sa, sb, rdy, dly);
    end

    bif.m1_req = 1'b0;
    bif.m2_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("final_idle", 0, 0, 2'b11, 3'b000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

- Shares the system bus between master 1 and master 2, and enables one of three slaves for each transaction.
- A requester wins by fixed rules when it is alone, and by round-robin when both request together.
- The winner is granted once its target slave is ready, and the grant is held until the transaction completes or times out.
- The block sits between the two master interfaces and the slave-select/bus-mux logic in `top_level`.

## Interface
Parameters:
- NUM_SLAVES, 3, number of slaves. Slave index is address bits [13:12], giving 4096 bytes per slave.
- TIMEOUT, 255, maximum cycles spent in WAIT_SLAVE or GRANT before the transaction is aborted.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  reset, synchronous and active-high.
- m1_req  in  1  master 1 bus request; held high for the whole transaction.
- m2_req  in  1  master 2 bus request; held high for the whole transaction.
- m1_slave_sel  in  2  master 1 target slave; valid while m1_req is high.
- m2_slave_sel  in  2  master 2 target slave; valid while m2_req is high.
- slave_ready  in  NUM_SLAVES  per-slave "ready to accept a new transaction".
- trans_done  in  1  one-cycle pulse from the active slave when the transaction is complete.
- m1_grant  out  1  master 1 owns the bus.
- m2_grant  out  1  master 2 owns the bus.
- slave_sel  out  2  bus mux select; 2'b11 means no slave.
- slave_en  out  NUM_SLAVES  one-hot enable for the selected slave.
- bus_busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on an invalid slave select or on a timeout.

## Operation
- All outputs are registered.
- Reset values: grants 0, slave_sel 2'b11, slave_en 0, bus_busy 0, err 0, state IDLE, last_winner = M2 (so M1 wins the first tie), counter 0.

States:
- IDLE: no requests → stay.
  - One request → that master wins.
  - Both requesting → the master that is not last_winner wins.
  - Latch winner ID and its slave_sel, then go to WAIT_SLAVE.
- WAIT_SLAVE:
  - Latched sel == 2'b11 → pulse err and go to RELEASE.
  - slave_ready[sel] = 1 → go to GRANT.
  - Otherwise count cycles; counter reaching TIMEOUT → pulse err and go to RELEASE.
  - Winner drops its request → go to RELEASE without granting.
- GRANT:
  - Winner's grant = 1, slave_sel = latched sel, slave_en = one-hot(sel).
  - trans_done or winner request dropped → go to RELEASE.
  - Counter reaching TIMEOUT → pulse err and go to RELEASE.
- RELEASE: all grants 0, slave_en 0, slave_sel 2'b11, last_winner ← winner, then go to IDLE.
- Losing master: its request is ignored (no grant, no error) until the arbiter returns to IDLE.
- Counter: width $clog2(TIMEOUT+1); cleared on every state entry; saturates and never wraps.
- Only the latched slave index is used; a change on mX_slave_sel after arbitration is ignored.
- trans_done outside GRANT is ignored.
- trans_done and a timeout in the same cycle: trans_done wins and err is not pulsed.

## Timing
- Request sampled high in IDLE at edge N → WAIT_SLAVE at N+1.
- With slave_ready high, grant and slave_en are high from N+2 (minimum latency 2 cycles).
- trans_done sampled at edge T → grant low from T+1 (RELEASE), IDLE at T+2.
- Earliest next grant is from T+4.
- err is high for exactly one cycle, in the cycle of entry to RELEASE.
- Reset asserted in any state → reset values on the next edge; an in-flight transaction is dropped with no err.
- Grants are mutually exclusive in every cycle.

## Structure
- Package `bus_pkg` holds:
  - state enum (IDLE, WAIT_SLAVE, GRANT, RELEASE)
  - master ID constants M1 and M2
  - SEL_NONE = 2'b11
  - SLAVE_ADDR_MSB = 13, SLAVE_ADDR_LSB = 12
  - default TIMEOUT
- Sub-module `arb_timeout_counter`: clear/enable inputs, saturating count, `expired` output.
- FSM, round-robin pointer and output registers stay in `bus_arbiter`.

## Test plan
- Lone request:
  - m1_req = 1, m1_slave_sel = 0, slave_ready = 3'b111.
  - Required: m1_grant = 1 and slave_en = 3'b001 two cycles later.
  - trans_done pulse → grant low the next cycle, bus_busy low one cycle after that.
- Tie, twice in a row (master returns to IDLE between the two ties):
  - m1_req = m2_req = 1 with sel 1 and 2 from reset.
  - Required: M1 is granted first (slave_en = 3'b010), M2 after its release (slave_en = 3'b100).
  - Repeat the tie → M1 again, because last_winner = M2.
- Slave not ready:
  - m2_req with sel 2 and slave_ready[2] = 0 for 10 cycles, then 1.
  - Required: m2_grant rises exactly 1 cycle after slave_ready[2] rises; err is never pulsed.
- Timeouts, with TIMEOUT = 15:
  - slave_ready held at 0 → err pulses once, grants stay 0, arbiter returns to IDLE.
  - Granted, then no trans_done → err pulses once, grant drops.
- Invalid select: m1_slave_sel = 2'b11 → err pulse, no grant, slave_sel stays 2'b11.
- Reset mid-GRANT: reset = 1 for one cycle → all outputs at reset values on the next edge, no err pulse.
